// File: rtl/impix_pio_pkg.sv
// Shared definitions for the impix switch/indicator PIO: register map, ID word and a
// counter-width helper.
package impix_pio_pkg;

  localparam logic [2:0] ADDR_SW_STATE = 3'd0;
  localparam logic [2:0] ADDR_LED_OUT  = 3'd1;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd6;
  localparam logic [2:0] ADDR_ID       = 3'd7;

  // Block ID; the revision nibble (bits 19:16) reads 0.
  localparam logic [31:0] ID_VALUE = 32'h1F10_0002;

  // Bits needed to hold 0..n, never less than 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/impix_pio_debounce.sv
// One switch bit: 2-flop synchroniser followed by a consecutive-mismatch debounce counter.
module impix_pio_debounce
  import impix_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_stable
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/impix_pio_ctrl.sv
// Avalon-MM PIO: debounced switches with edge capture and maskable IRQ, plus LED register.
// Defining IMPIX_PIO_BLINK_EN adds per-LED blinking from a free-running prescaler.
module impix_pio_ctrl
  import impix_pio_pkg::*;
#(
  parameter int unsigned SW_W            = 4,
  parameter int unsigned LED_W           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned BLINK_DIV       = 25000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  input  logic [SW_W-1:0]  switches_export,
  output logic [LED_W-1:0] indicators_export,
  output logic             irq
);

  if (SW_W < 1 || SW_W > 32 || LED_W < 1 || LED_W > 32 ||
      DEBOUNCE_CYCLES < 1 || BLINK_DIV < 1) begin : g_bad_param
    $error("impix_pio_ctrl: parameter out of range");
  end

  logic [SW_W-1:0]  w_stable;
  logic [SW_W-1:0]  r_stable_d;
  logic [SW_W-1:0]  r_edge_cap;
  logic [SW_W-1:0]  r_irq_mask;
  logic [SW_W-1:0]  r_rise_en;
  logic [SW_W-1:0]  r_fall_en;
  logic [LED_W-1:0] r_led;
  logic             r_irq;
  logic [31:0]      r_rdata;
  logic             r_rvalid;
  logic [31:0]      w_rdata;
  logic [31:0]      w_blink_rd;
  logic [SW_W-1:0]  w_set;
  logic [SW_W-1:0]  w_w1c;
  logic             w_unused;

  for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw
    impix_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .i_pin   (switches_export[gi]),
      .o_stable(w_stable[gi])
    );
  end

  assign w_set = (w_stable & ~r_stable_d & r_rise_en) | (~w_stable & r_stable_d & r_fall_en);
  assign w_w1c = (avs_write && avs_address == ADDR_EDGE_CAP) ? avs_writedata[SW_W-1:0] : '0;
  assign w_unused = ^avs_writedata;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_stable_d <= '0;
      r_edge_cap <= '0;
      r_irq_mask <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_led      <= '0;
      r_irq      <= 1'b0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_stable_d <= w_stable;
      // Set is OR-ed in after the clear, so an edge landing with its own W1C survives.
      r_edge_cap <= (r_edge_cap & ~w_w1c) | w_set;
      r_irq      <= |(r_edge_cap & r_irq_mask);
      if (avs_write && avs_address == ADDR_LED_OUT)  r_led      <= avs_writedata[LED_W-1:0];
      if (avs_write && avs_address == ADDR_IRQ_MASK) r_irq_mask <= avs_writedata[SW_W-1:0];
      if (avs_write && avs_address == ADDR_RISE_EN)  r_rise_en  <= avs_writedata[SW_W-1:0];
      if (avs_write && avs_address == ADDR_FALL_EN)  r_fall_en  <= avs_writedata[SW_W-1:0];
      r_rvalid <= avs_read;
      if (avs_read) r_rdata <= w_rdata;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no address path leaves w_rdata unassigned (no latch).
    w_rdata = '0;
    case (avs_address)
      ADDR_SW_STATE: w_rdata = 32'(w_stable);
      ADDR_LED_OUT:  w_rdata = 32'(r_led);
      ADDR_EDGE_CAP: w_rdata = 32'(r_edge_cap);
      ADDR_IRQ_MASK: w_rdata = 32'(r_irq_mask);
      ADDR_RISE_EN:  w_rdata = 32'(r_rise_en);
      ADDR_FALL_EN:  w_rdata = 32'(r_fall_en);
      ADDR_BLINK_EN: w_rdata = w_blink_rd;
      ADDR_ID:       w_rdata = ID_VALUE;
      default:       w_rdata = '0;
    endcase
  end

`ifdef IMPIX_PIO_BLINK_EN
  localparam int unsigned PW = cnt_width(BLINK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic             r_phase;
  logic [LED_W-1:0] r_blink_en;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_presc    <= '0;
      r_phase    <= 1'b0;
      r_blink_en <= '0;
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (avs_write && avs_address == ADDR_BLINK_EN) r_blink_en <= avs_writedata[LED_W-1:0];
    end
  end

  assign w_blink_rd        = 32'(r_blink_en);
  assign indicators_export = r_led & ~(r_blink_en & {LED_W{~r_phase}});
`else
  assign w_blink_rd        = '0;
  assign indicators_export = r_led;
`endif

  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign irq               = r_irq;

endmodule

// File: tb/tb_impix_pio_ctrl.sv
// Randomised scoreboard bench for impix_pio_ctrl against a behavioural register-file model.
module tb_impix_pio_ctrl;

  localparam int SW_W  = 4;
  localparam int LED_W = 4;
  localparam int DC    = 8;
  localparam int BDIV  = 4;

  logic             clk_clk = 1'b0;
  logic             reset_reset_n = 1'b1;
  logic [2:0]       avs_address = '0;
  logic             avs_read = 1'b0;
  logic             avs_write = 1'b0;
  logic [31:0]      avs_writedata = '0;
  logic [31:0]      avs_readdata;
  logic             avs_readdatavalid;
  logic [SW_W-1:0]  switches_export = '0;
  logic [LED_W-1:0] indicators_export;
  logic             irq;

  always #5 clk_clk = ~clk_clk;

  impix_pio_ctrl #(
    .SW_W(SW_W), .LED_W(LED_W), .DEBOUNCE_CYCLES(DC), .BLINK_DIV(BDIV)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .switches_export(switches_export),
    .indicators_export(indicators_export), .irq(irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]      exp_q[$];
  logic [SW_W-1:0]  pin_hist[$];
  bit               m_valid;
  int unsigned      m_edges;
  bit               m_irq;
  logic [SW_W-1:0]  m_stable, m_stable_d, m_cap, m_mask, m_rise, m_fall;
  logic [LED_W-1:0] m_led, m_blink;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_stable);
      3'd1:    return 32'(m_led);
      3'd2:    return 32'(m_cap);
      3'd3:    return 32'(m_mask);
      3'd4:    return 32'(m_rise);
      3'd5:    return 32'(m_fall);
`ifdef IMPIX_PIO_BLINK_EN
      3'd6:    return 32'(m_blink);
`else
      3'd6:    return 32'h0;
`endif
      default: return 32'h1F10_0002;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] model_ind();
    logic [LED_W-1:0] ind;
    bit ph;
    ind = m_led;
    ph  = ((m_edges / BDIV) % 2) == 1;
`ifdef IMPIX_PIO_BLINK_EN
    for (int i = 0; i < LED_W; i++)
      if (m_blink[i]) ind[i] = m_led[i] & ph;
`endif
    return ind;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pin_hist.delete();
    repeat (DC + 1) pin_hist.push_back('0);
    m_valid = 0; m_edges = 0; m_irq = 0;
    m_stable = '0; m_stable_d = '0; m_cap = '0; m_mask = '0;
    m_rise = '0; m_fall = '0; m_led = '0; m_blink = '0;
  endtask

  // A bit's debounced value flips once the synchronised pin (pin two edges back)
  // has disagreed with it on each of the last DC edges.
  task automatic model_step();
    logic [SW_W-1:0] nstable, rise, fall, w1c;
    int sz;
    bit flip;
    if (avs_read) exp_q.push_back(model_read(avs_address));
    m_valid = avs_read;
    sz = pin_hist.size();
    nstable = m_stable;
    for (int b = 0; b < SW_W; b++) begin
      flip = 1;
      for (int d = 0; d < DC; d++)
        if (pin_hist[sz - 2 - d][b] == m_stable[b]) flip = 0;
      if (flip) nstable[b] = ~m_stable[b];
    end
    rise = m_stable & ~m_stable_d;
    fall = ~m_stable & m_stable_d;
    w1c  = (avs_write && avs_address == 3'd2) ? avs_writedata[SW_W-1:0] : '0;
    m_irq = |(m_cap & m_mask);
    m_cap = (m_cap & ~w1c) | (rise & m_rise) | (fall & m_fall);
    m_stable_d = m_stable;
    m_stable   = nstable;
    if (avs_write) begin
      case (avs_address)
        3'd1: m_led  = avs_writedata[LED_W-1:0];
        3'd3: m_mask = avs_writedata[SW_W-1:0];
        3'd4: m_rise = avs_writedata[SW_W-1:0];
        3'd5: m_fall = avs_writedata[SW_W-1:0];
`ifdef IMPIX_PIO_BLINK_EN
        3'd6: m_blink = avs_writedata[LED_W-1:0];
`endif
        default: ;
      endcase
    end
    pin_hist.push_back(switches_export);
    if (pin_hist.size() > DC + 1) void'(pin_hist.pop_front());
    m_edges++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_clk or negedge reset_reset_n);
      if (!reset_reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        check("rst_rdvalid", 32'(avs_readdatavalid), 32'h0);
        check("rst_indicators", 32'(indicators_export), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
      end else begin
        check("rdvalid", 32'(avs_readdatavalid), 32'(m_valid));
        if (avs_readdatavalid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rdata: valid with data %h but no read expected", avs_readdata);
          end else begin
            check("rdata", avs_readdata, exp_q.pop_front());
          end
        end
        check("indicators", 32'(indicators_export), 32'(model_ind()));
        check("irq", 32'(irq), 32'(m_irq));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(0, 0, 3'd0, 32'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(0, 1, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    bus(1, 0, a, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk_clk);
    #2;
    reset_reset_n = 1'b0;
    avs_read = 1'b0; avs_write = 1'b0; switches_export = '0;
    repeat (3) @(posedge clk_clk);
    #2;
    reset_reset_n = 1'b1;
  endtask

  int          hold;
  int unsigned op;
  logic [2:0]  ra;

  initial begin
    #1 reset_reset_n = 1'b0;
    repeat (3) @(posedge clk_clk);
    #2 reset_reset_n = 1'b1;
    idle(2);

    // Traffic, then a reset with a read still in flight; all registers must return to 0.
    wr(3'd1, 32'h5); wr(3'd3, 32'hF); wr(3'd4, 32'hF);
    switches_export = 4'b0001;
    idle(DC + 4);
    rd(3'd1); rd(3'd2);
    do_reset();
    for (int a = 0; a < 8; a++) rd(3'(a));
    idle(3);

    // Debounce: long level on switch 0, then a 5-clock glitch on switch 1.
    idle(1);
    switches_export = 4'b0001;
    repeat (DC + 6) rd(3'd0);
    idle(1);
    switches_export = 4'b0011;
    repeat (5) rd(3'd0);
    switches_export = 4'b0001;
    repeat (DC + 6) rd(3'd0);

    // Rising capture and interrupt, then W1C clear.
    switches_export = 4'b0000;
    idle(DC + 4);
    wr(3'd2, 32'hF); wr(3'd4, 32'h1); wr(3'd3, 32'h1);
    idle(1);
    switches_export = 4'b0001;
    repeat (DC + 5) rd(3'd2);
    wr(3'd2, 32'h1);
    repeat (3) rd(3'd2);

    // Fall on bit 2 lands on the same edge as a W1C of bit 2: the set must win.
    switches_export = 4'b0101;
    idle(DC + 5);
    wr(3'd5, 32'h4); wr(3'd2, 32'hF);
    idle(1);
    switches_export = 4'b0001;
    idle(DC + 1);
    wr(3'd2, 32'h4);
    rd(3'd2); rd(3'd2);

    // Bus timing: LED write, single read, back-to-back reads, read+write together.
    wr(3'd1, 32'hA);
    idle(1);
    rd(3'd1);
    idle(2);
    rd(3'd0); rd(3'd1);
    bus(1, 1, 3'd1, 32'h3);
    rd(3'd1);
    idle(2);

    // Blink on LED 0.
    wr(3'd1, 32'h1); wr(3'd6, 32'h1);
    idle(3 * BDIV);
    rd(3'd6);
    idle(2);

    // Randomised traffic with switch levels held for random lengths (some shorter than DC).
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      op = $urandom_range(0, 99);
      ra = 3'($urandom_range(0, 7));
      bus(op < 40, (op >= 30) && (op < 60), ra, $urandom);
      if (hold == 0) begin
        switches_export = SW_W'($urandom);
        hold = $urandom_range(1, 2 * DC);
      end else begin
        hold--;
      end
    end
    idle(4);
    check("pending_reads", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/impix_pio_ctrl.md
Name: impix_pio_ctrl

Overview:
Parametrised successor to the fixed 4-bit switch/indicator PIO pair in the impix system. It provides an Avalon-MM slave with a register file for N switch inputs and M indicator outputs. The switch path adds synchronisation, per-bit debounce, edge capture and a maskable interrupt. It sits in the FPGA fabric on the HPS lightweight bridge, and its conduits go to the board switches and LEDs.

Parameters:
SW_W, 4, number of switch inputs (1..32)
LED_W, 4, number of indicator outputs (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced bit changes (>=1)
BLINK_DIV, 25000000, blink half-period in clocks (used only with IMPIX_PIO_BLINK_EN)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
avs_address  in  3  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered
avs_readdatavalid  out  1  read data valid
switches_export  in  SW_W  raw asynchronous switch pins
indicators_export  out  LED_W  indicator drive
irq  out  1  level interrupt, active high

Behaviour:
- Reset: clk_clk is the single clock. reset_reset_n is asynchronous and active-low. While it is low, all registers, counters and outputs go to 0: avs_readdata=0, avs_readdatavalid=0, indicators_export=0, irq=0. The debounced state resets to 0.
- Synchronisation and debounce:
  - Each switch bit passes through a 2-flop synchroniser.
  - Each bit has a counter, width clog2(DEBOUNCE_CYCLES+1).
  - If sync != stable, the counter increments. If sync == stable, the counter clears.
  - When the counter == DEBOUNCE_CYCLES-1 and sync still mismatches, stable <= sync and the counter clears.
  - Pin-to-stable latency: 2 + DEBOUNCE_CYCLES clocks.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
- Edge capture:
  - rise = stable & ~stable_d; fall = ~stable & stable_d.
  - EDGE_CAP[i] is set by (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - Writing 1 clears a bit (W1C). If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Interrupt: irq is registered, irq <= |(EDGE_CAP & IRQ_MASK). It asserts 1 cycle after the capture bit sets and deasserts 1 cycle after the clear.
- Register map (word address; unused upper bits read 0):
  - 0: SW_STATE, RO, debounced state.
  - 1: LED_OUT, RW, LED_W bits.
  - 2: EDGE_CAP, R/W1C.
  - 3: IRQ_MASK, RW.
  - 4: RISE_EN, RW.
  - 5: FALL_EN, RW.
  - 6: BLINK_EN, RW; reads 0 and ignores writes without the macro.
  - 7: ID, RO, 32'h1F1X_0002.
- Bus handshake:
  - Fixed read latency 1: for avs_read in cycle T, avs_readdata and avs_readdatavalid=1 appear in T+1. avs_readdatavalid is 0 otherwise, and avs_readdata holds its last value.
  - A write takes effect at the clock edge of the strobe. No waitrequest.
  - If read and write are asserted together, both execute. The read returns the pre-write value.
  - Reading EDGE_CAP does not clear it.
- indicators_export = LED_OUT, registered, with no extra latency beyond the register.
- Reset mid-operation: any pending readdatavalid is dropped, debounce counters clear, and captures are lost.

Optional Feature:
- Macro: IMPIX_PIO_BLINK_EN.
- With the macro:
  - A free-running prescaler counts 0..BLINK_DIV-1, toggling a phase bit at each wrap.
  - indicators_export[i] = BLINK_EN[i] ? (LED_OUT[i] & phase) : LED_OUT[i].
  - phase resets to 0. Writing BLINK_EN does not reset the prescaler.
- Without the macro: no prescaler logic, BLINK_EN reads 0, and indicators_export = LED_OUT.

Decomposition:
- Package impix_pio_pkg holds:
  - Register address localparams (ADDR_SW_STATE..ADDR_ID).
  - The ID constant.
  - A clog2-based counter width function.
- One sub-module, impix_pio_debounce: a single-bit synchroniser plus debounce counter. It is instantiated SW_W times with a generate loop, takes DEBOUNCE_CYCLES, and outputs stable.

Test Plan:
- Reset behaviour: hold reset_reset_n=0 mid-traffic, read every register after release -> all read 0 except ID, which reads 32'h1F1X_0002; indicators_export=0 and irq=0.
- Debounce: DEBOUNCE_CYCLES=8. Set switch 0 high -> SW_STATE reads 1 exactly 10 clocks after the pin change. A 5-clock pulse on switch 1 -> SW_STATE never changes.
- Rising capture and interrupt: RISE_EN=1, IRQ_MASK=1, switch 0 rises -> EDGE_CAP=1 and irq=1 one cycle later. Write 1 to addr 2 -> EDGE_CAP=0 and irq=0 one cycle after the write.
- Simultaneous events: align a fall on bit 2 (FALL_EN=4) with a W1C of 4 in the same cycle -> EDGE_CAP bit 2 remains 1.
- Bus timing: write LED_OUT=4'hA -> indicators_export=4'hA on the next edge. Read addr 1 -> readdatavalid pulses for exactly 1 cycle at T+1 with data 32'hA. Back-to-back reads on addresses 0 and 1 -> two consecutive valid cycles in order.
- Blink (with IMPIX_PIO_BLINK_EN): BLINK_DIV=4, LED_OUT=1, BLINK_EN=1 -> indicators_export[0] toggles every 4 clocks. Without the macro -> it stays 1, and BLINK_EN reads 0.
